// File: rtl/nibble_serial_subtractor.sv
// Serial WIDTH-bit subtractor: a - b - bin computed one nibble per clock through a
// 4-bit carry-lookahead slice, with valid/ready handshakes on both sides.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int N    = WIDTH / 4;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // 4-bit generate/propagate lookahead adder; returns {carry_out, sum}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

  state_t            state_r;
  state_t            state_s;
  logic [IDXW-1:0]   idx_r;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic              borrow_r;
  logic [WIDTH-1:0]  work_r;
  logic [WIDTH-1:0]  work_s;
  logic [4:0]        nib_s;
  logic              accept_s;
  logic              last_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [WIDTH-1:0]  diff_r;
  logic              bout_r;
  logic              ovf_r;
  logic              zero_r;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign diff      = diff_r;
  assign bout      = bout_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

  // Next-state decode and the current nibble slice (subtract as a + ~b + ~borrow).
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    last_s   = 1'b0;
    nib_s    = cla4(a_r[{idx_r, 2'b00} +: 4], ~b_r[{idx_r, 2'b00} +: 4], ~borrow_r);
    work_s   = work_r;
    work_s[{idx_r, 2'b00} +: 4] = nib_s[3:0];
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          state_s  = RUN;
          accept_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (idx_r == LAST_IDX) begin
          state_s = DONE;
          last_s  = 1'b1;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Control state and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  // Operand capture and per-nibble working state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      idx_r    <= {IDXW{1'b0}};
      work_r   <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      a_r      <= a;
      b_r      <= b;
      borrow_r <= bin;
      idx_r    <= {IDXW{1'b0}};
      work_r   <= {WIDTH{1'b0}};
    end else if (state_r == RUN) begin
      work_r   <= work_s;
      borrow_r <= ~nib_s[4];
      idx_r    <= last_s ? {IDXW{1'b0}} : idx_r + IDXW'(1);
    end
  end

  // Result registers: loaded once on the final nibble, otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_r <= {WIDTH{1'b0}};
      bout_r <= 1'b0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else if (last_s) begin
      diff_r <= work_s;
      bout_r <= ~nib_s[4];
      ovf_r  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (work_s[WIDTH-1] != a_r[WIDTH-1]);
      zero_r <= (work_s == {WIDTH{1'b0}});
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor (WIDTH = 16): directed vectors,
// random operands against an arithmetic reference model, handshake timing and reset.
module tb_nibble_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic; returns {bout, ovf, zero, diff}.
  function automatic logic [18:0] ref_sub(input logic [15:0] x, input logic [15:0] y,
                                          input logic bi);
    int r;
    logic [15:0] d;
    r = int'(x) - int'(y) - int'(bi);
    d = r[15:0];
    return {(r < 0), (x[15] != y[15]) && (d[15] != x[15]), (d == 16'h0000), d};
  endfunction

  task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic bi);
    int n = 0;
    while (!in_ready && n < 30) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL accept_wait in_ready=%0b required 1", in_ready);
    end
    a = x; b = y; bin = bi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 16'h0; b = 16'h0; bin = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({out_valid, in_ready, diff, bout, ovf, zero} !== 21'h0) begin
      errors++; $display("FAIL reset_outputs got %h required 0", {out_valid, in_ready, diff, bout, ovf, zero});
    end
    repeat (3) @(posedge clk);
    #1; checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b required 0", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    #1; checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL in_ready_before_edge got %0b required 0", in_ready); end
    @(posedge clk); #1; checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL in_ready_after_edge got %0b required 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [15:0] va [5] = '{16'h1234, 16'h1000, 16'h0000, 16'h8000, 16'h5555};
    logic [15:0] vb [5] = '{16'h0234, 16'h0001, 16'h0001, 16'h0001, 16'h5554};
    logic        vi [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] ed [5] = '{16'h1000, 16'h0FFF, 16'hFFFF, 16'h7FFF, 16'h0000};
    logic [2:0]  ef [5] = '{3'b000, 3'b000, 3'b100, 3'b010, 3'b001};  // {bout, ovf, zero}
    int lat;
    for (int i = 0; i < 5; i++) begin
      start_op(va[i], vb[i], vi[i]);
      wait_result(lat);
      checks++;
      if (lat != 4) begin errors++; $display("FAIL dir_latency[%0d] got %0d required 4", i, lat); end
      checks++;
      if (diff !== ed[i]) begin errors++; $display("FAIL dir_diff[%0d] got %h required %h", i, diff, ed[i]); end
      checks++;
      if ({bout, ovf, zero} !== ef[i]) begin
        errors++; $display("FAIL dir_flags[%0d] got %b required %b", i, {bout, ovf, zero}, ef[i]);
      end
      release_result();
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++; $display("FAIL dir_release[%0d] got %b required 01", i, {out_valid, in_ready});
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] x, y;
    logic        bi;
    logic [18:0] m;
    int lat;
    for (int i = 0; i < 30; i++) begin
      x = 16'($urandom); y = 16'($urandom); bi = 1'($urandom);
      if (i % 7 == 0) y = x;
      m = ref_sub(x, y, bi);
      start_op(x, y, bi);
      wait_result(lat);
      checks++;
      if ({lat == 4, bout, ovf, zero, diff} !== {1'b1, m}) begin
        errors++;
        $display("FAIL rnd[%0d] %h-%h-%0b got lat=%0d res=%h required lat=4 res=%h", i, x, y, bi, lat,
                 {bout, ovf, zero, diff}, m);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    logic [18:0] snap;
    int lat;
    start_op(16'h1000, 16'h0001, 1'b0);
    wait_result(lat);
    snap = {bout, ovf, zero, diff};
    checks++;
    if (snap !== 19'h00FFF) begin errors++; $display("FAIL bp_result got %h required 00fff", snap); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, bout, ovf, zero, diff} !== {2'b10, 19'h00FFF}) begin
        errors++; $display("FAIL bp_hold[%0d] got %b_%h required 10_00fff", i, {out_valid, in_ready},
                           {bout, ovf, zero, diff});
      end
    end
    in_valid = 1'b0;
    release_result();
    checks++;
    if ({out_valid, in_ready, diff} !== {2'b01, 16'h0FFF}) begin
      errors++; $display("FAIL bp_release got %b_%h required 01_0fff", {out_valid, in_ready}, diff);
    end
    start_op(16'h0000, 16'h0001, 1'b0);
    wait_result(lat);
    checks++;
    if ({bout, ovf, zero, diff} !== 19'h4FFFF) begin
      errors++; $display("FAIL bp_next got %h required 4ffff", {bout, ovf, zero, diff});
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [15:0] x, y;
    logic        bi;
    logic [18:0] m;
    int stamp, prev, lat, n;
    prev = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!in_ready && n < 30) begin @(posedge clk); #1; n++; end
      stamp = cyc;
      x = 16'($urandom); y = 16'($urandom); bi = 1'($urandom);
      m = ref_sub(x, y, bi);
      a = x; b = y; bin = bi; in_valid = 1'b1;
      @(posedge clk); #1;
      if (i > 0) begin
        checks++;
        if (stamp - prev != 6) begin errors++; $display("FAIL b2b_spacing[%0d] got %0d required 6", i, stamp - prev); end
      end
      prev = stamp;
      a = 16'($urandom); b = 16'($urandom);
      if (i == 3) in_valid = 1'b0;
      wait_result(lat);
      checks++;
      if ({lat == 4, bout, ovf, zero, diff} !== {1'b1, m}) begin
        errors++; $display("FAIL b2b_result[%0d] got lat=%0d res=%h required lat=4 res=%h", i, lat,
                           {bout, ovf, zero, diff}, m);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_isolation();
    logic [18:0] m;
    int lat;
    m = ref_sub(16'hC3A5, 16'h1F2E, 1'b1);
    start_op(16'hC3A5, 16'h1F2E, 1'b1);
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      @(posedge clk); #1;
    end
    wait_result(lat);
    checks++;
    if ({lat == 1, bout, ovf, zero, diff} !== {1'b1, m}) begin
      errors++; $display("FAIL isolation got lat=%0d res=%h required lat=1 res=%h", lat,
                         {bout, ovf, zero, diff}, m);
    end
    release_result();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bit seen;
    start_op(16'h1234, 16'h0234, 1'b0);
    wait_result(lat);
    release_result();
    start_op(16'hABCD, 16'h1111, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1; checks++;
    if ({out_valid, in_ready, diff, bout, ovf, zero} !== 21'h0) begin
      errors++; $display("FAIL midrun_reset got %h required 0", {out_valid, in_ready, diff, bout, ovf, zero});
    end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midrun_stale out_valid seen=1 required 0"); end
    start_op(16'hFFFF, 16'hFFFF, 1'b0);
    wait_result(lat);
    checks++;
    if ({lat == 4, bout, ovf, zero, diff} !== {1'b1, 19'h10000}) begin
      errors++; $display("FAIL after_reset got lat=%0d res=%h required lat=4 res=10000", lat,
                         {bout, ovf, zero, diff});
    end
    release_result();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_isolation();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
